// File: rtl/spi_slave_fifo_pkg.sv
// Shared types and helpers for the oversampling SPI slave and its word FIFOs.
package spiSlavePkg;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spiMode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spiState_t;

    function automatic int levelWdt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spi_slave_fifo_fifo.sv
// spiFifo: synchronous word FIFO with first-word fall-through and an occupancy count.
module spiFifo
    import spiSlavePkg::*;
#(
    parameter int WDT   = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WDT-1:0]              push_data,
    input  logic                        pop,
    output logic [WDT-1:0]              pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [levelWdt(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = levelWdt(DEPTH);

    logic [WDT-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // An empty FIFO presents zero rather than stale storage on its head.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave oversampled on clk, mode latched per frame, TX/RX word FIFOs.
// Define SPI_SLAVE_FIFO_FLAGS_EN to enable the sticky txUnderflow/rxOverflow flags and flagClr.
module spi_slave_fifo
    import spiSlavePkg::*;
#(
    parameter int                  DATA_WDT   = 8,
    parameter int                  FIFO_DEPTH = 16,
    parameter logic                MSB_FIRST  = 1'b1,
    parameter logic [DATA_WDT-1:0] TX_IDLE    = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ssel,
    input  logic                                sclk,
    input  logic                                mosi,
    output logic                                miso,
    output logic                                misoOe,
    input  logic                                cpol,
    input  logic                                cpha,
    input  logic [DATA_WDT-1:0]                 txData,
    input  logic                                txWr,
    output logic                                txFull,
    output logic [levelWdt(FIFO_DEPTH)-1:0]     txLevel,
    output logic [DATA_WDT-1:0]                 rxData,
    input  logic                                rxRd,
    output logic                                rxEmpty,
    output logic [levelWdt(FIFO_DEPTH)-1:0]     rxLevel,
    output logic                                spiBusy,
    output logic                                spiStart,
    output logic                                spiEnd,
    output logic                                txUnderflow,
    output logic                                rxOverflow,
    input  logic                                flagClr
);

    localparam int               CNT_W    = $clog2(DATA_WDT);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WDT - 1);

    // [0] metastability stage, [1] synchronised value, [2] previous synchronised value
    logic [2:0]          ssel_pipe;
    logic [2:0]          sclk_pipe;
    logic [2:0]          mosi_pipe;

    spiState_t           state_q;
    spiState_t           state_d;
    spiMode_t            mode_q;
    logic                frame_start;
    logic                frame_end;
    logic                in_frame;

    logic                ssel_fall;
    logic                ssel_rise;
    logic                sclk_edge;
    logic                lead_edge;
    logic                trail_edge;
    logic                sample_edge;
    logic                shift_edge;
    logic                word_done;

    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_WDT-1:0] tx_shift;
    logic [DATA_WDT-1:0] tx_shifted;
    logic [DATA_WDT-1:0] tx_head;
    logic [DATA_WDT-1:0] tx_next;
    logic [DATA_WDT-1:0] rx_shift;
    logic [DATA_WDT-1:0] rx_word;
    logic                tx_fresh;
    logic                tx_load;
    logic                tx_pop;
    logic                tx_empty;
    logic                rx_push;
    logic                rx_full;
    logic                underflow_evt;
    logic                overflow_evt;

    // ssel resets to the selected level so a pin held low through reset never fakes a frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ssel_pipe <= '0;
            sclk_pipe <= '0;
            mosi_pipe <= '0;
        end else begin
            ssel_pipe <= {ssel_pipe[1:0], ssel};
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            mosi_pipe <= {mosi_pipe[1:0], mosi};
        end
    end

    assign ssel_fall  = ssel_pipe[2] & ~ssel_pipe[1];
    assign ssel_rise  = ~ssel_pipe[2] & ssel_pipe[1];
    assign sclk_edge  = sclk_pipe[2] ^ sclk_pipe[1];
    assign lead_edge  = sclk_edge & (sclk_pipe[1] != mode_q.cpol);
    assign trail_edge = sclk_edge & (sclk_pipe[1] == mode_q.cpol);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            spiStart <= 1'b0;
            spiEnd   <= 1'b0;
        end else begin
            state_q  <= state_d;
            spiStart <= frame_start;
            spiEnd   <= frame_end;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssel_rise) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_frame    = (state_q == ACTIVE) && !frame_end;
    assign sample_edge = in_frame & (mode_q.cpha ? trail_edge : lead_edge);
    assign shift_edge  = in_frame & (mode_q.cpha ? lead_edge : trail_edge);
    assign word_done   = sample_edge && (bit_cnt == LAST_BIT);

    assign tx_load       = frame_start | word_done;
    assign tx_pop        = tx_load & ~tx_empty;
    assign underflow_evt = tx_load & tx_empty;
    assign tx_next       = tx_empty ? TX_IDLE : tx_head;
    assign rx_push       = word_done;
    assign overflow_evt  = word_done & rx_full;

    assign rx_word    = MSB_FIRST ? {rx_shift[DATA_WDT-2:0], mosi_pipe[2]}
                                  : {mosi_pipe[2], rx_shift[DATA_WDT-1:1]};
    assign tx_shifted = MSB_FIRST ? {tx_shift[DATA_WDT-2:0], 1'b0}
                                  : {1'b0, tx_shift[DATA_WDT-1:1]};

    // A freshly loaded word is already on miso, so the next shift edge only consumes tx_fresh.
    // In CPHA=0 the first bit must be valid before any edge, so the frame-start word is not fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            tx_fresh <= 1'b0;
            rx_shift <= '0;
        end else if (frame_start) begin
            mode_q.cpol <= cpol;
            mode_q.cpha <= cpha;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= tx_next;
            tx_fresh    <= cpha;
        end else begin
            if (sample_edge) begin
                rx_shift <= rx_word;
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            if (word_done) begin
                tx_shift <= tx_next;
                tx_fresh <= 1'b1;
            end else if (shift_edge) begin
                if (tx_fresh) tx_fresh <= 1'b0;
                else          tx_shift <= tx_shifted;
            end
        end
    end

    assign spiBusy = (state_q == ACTIVE);
    assign misoOe  = (state_q == ACTIVE);
    assign miso    = (state_q == ACTIVE) &&
                     (MSB_FIRST ? tx_shift[DATA_WDT-1] : tx_shift[0]);

`ifdef SPI_SLAVE_FIFO_FLAGS_EN
    // A new error event in the same cycle as flagClr leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txUnderflow <= 1'b0;
            rxOverflow  <= 1'b0;
        end else begin
            if (underflow_evt) txUnderflow <= 1'b1;
            else if (flagClr)  txUnderflow <= 1'b0;
            if (overflow_evt)  rxOverflow  <= 1'b1;
            else if (flagClr)  rxOverflow  <= 1'b0;
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = flagClr ^ underflow_evt ^ overflow_evt;
    assign txUnderflow        = 1'b0;
    assign rxOverflow         = 1'b0;
`endif

    spiFifo #(
        .WDT   (DATA_WDT),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (txWr),
        .push_data (txData),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (txFull),
        .empty     (tx_empty),
        .level     (txLevel)
    );

    spiFifo #(
        .WDT   (DATA_WDT),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rxRd),
        .pop_data  (rxData),
        .full      (rx_full),
        .empty     (rxEmpty),
        .level     (rxLevel)
    );

endmodule
